// File: rtl/seq_mult_ctrl.sv
// ============================================================================
// Module      : seq_mult_ctrl
// Description : FSM controller that sequences a shift-add multiplier datapath.
//               It accepts operands on a valid/ready handshake, runs one
//               add/shift iteration per multiplier bit, then holds the
//               response until it is consumed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mult_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    input  logic [WIDTH-1:0] mr_i,
    output logic             mr_ld_o,
    output logic             md_ld_o,
    output logic             rs_clear_o,
    output logic             rs_load_o,
    output logic             rs_shr_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] bit_idx_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BIT   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] bit_idx_q;
    logic [CNT_W-1:0] bit_idx_d;
    logic             w_last;

    assign w_last = (bit_idx_q == c_last_idx);

    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        mr_ld_o      = 1'b0;
        md_ld_o      = 1'b0;
        rs_clear_o   = 1'b0;
        rs_load_o    = 1'b0;
        rs_shr_o     = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    mr_ld_o    = 1'b1;
                    md_ld_o    = 1'b1;
                    rs_clear_o = 1'b1;
                    bit_idx_d  = '0;
                    state_d    = S_BIT;
                end
            end
            S_BIT: begin
                // A set bit costs an extra cycle: add now, shift in SHIFT.
                if (mr_i[bit_idx_q]) begin
                    rs_load_o = 1'b1;
                    state_d   = S_SHIFT;
                end else begin
                    rs_shr_o = 1'b1;
                    if (w_last) begin
                        state_d = S_DONE;
                    end else begin
                        bit_idx_d = bit_idx_q + CNT_W'(1);
                    end
                end
            end
            S_SHIFT: begin
                rs_shr_o = 1'b1;
                if (w_last) begin
                    state_d = S_DONE;
                end else begin
                    bit_idx_d = bit_idx_q + CNT_W'(1);
                    state_d   = S_BIT;
                end
            end
            S_DONE: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    assign busy_o    = (state_q != S_IDLE);
    assign bit_idx_o = bit_idx_q;

endmodule

`default_nettype wire
